// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: datapath width, opcode
// encoding and the arbiter FSM state encoding.
package alu_pkg;

   localparam int WIDTH = 20;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_ADD  = 3'd3,
      OP_SUB  = 3'd4,
      OP_NOT  = 3'd5,
      OP_PASS = 3'd6,
      OP_RSVD = 3'd7
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: opcode and operands in, result, carry and
// reserved-opcode error out. Arithmetic is done one bit wider than the
// operands so the top bit is the carry (ADD) or no-borrow (SUB); logic ops
// leave that bit clear so carry reads 0 for them.
module alu_core #(
   parameter int WIDTH = alu_pkg::WIDTH
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             err
);
   import alu_pkg::*;

   logic [WIDTH:0] wide;

   // Select the operation; SUB is a plus the inverted b plus one so the
   // extra bit comes out as the no-borrow flag. Reserved opcode yields zero.
   always_comb begin
      wide = '0;
      err  = 1'b0;
      case (alu_op_t'(op))
         OP_AND:  wide = {1'b0, a & b};
         OP_OR:   wide = {1'b0, a | b};
         OP_XOR:  wide = {1'b0, a ^ b};
         OP_ADD:  wide = {1'b0, a} + {1'b0, b};
         OP_SUB:  wide = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
         OP_NOT:  wide = {1'b0, ~a};
         OP_PASS: wide = {1'b0, a};
         default: begin
            wide = '0;
            err  = 1'b1;
         end
      endcase
   end

   assign result = wide[WIDTH-1:0];
   assign carry  = wide[WIDTH];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter and sequencer in front of the shared ALU.
// Requester 0 is instruction issue, requester 1 the address/aux unit.
// Each operation walks IDLE -> EXEC -> RESP; the response is held until the
// consumer takes it.
// Optional feature: define ALU_ARB_ROUND_ROBIN_EN for round-robin tie-break
// through last_grant. Without it requester 0 always wins a tie and
// requester 1 may starve.
module alu_arbiter #(
   parameter int WIDTH = alu_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   input  logic [2:0]       req_op0,
   input  logic [2:0]       req_op1,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   output logic [1:0]       req_ready,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_carry,
   output logic             rsp_zero,
   output logic             rsp_err
);
   import alu_pkg::*;

   arb_state_t       state;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             id_q;
   logic [1:0]       grant;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;
   logic             alu_err;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .result (alu_result),
      .carry  (alu_carry),
      .err    (alu_err)
   );

`ifdef ALU_ARB_ROUND_ROBIN_EN
   logic last_grant;

   // Grant only while idle and out of reset. On a tie the requester that
   // did not win the previous handshake goes first; a lone request always wins.
   always_comb begin
      grant = 2'b00;
      if (!rst && state == IDLE) begin
         if (req_valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
         end else if (req_valid[0]) begin
            grant = 2'b01;
         end else if (req_valid[1]) begin
            grant = 2'b10;
         end
      end
   end

   // Remember who won, but only when a handshake actually completes so a
   // withdrawn request does not disturb the rotation. Starts at 1 so
   // requester 0 wins the very first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (grant != 2'b00) begin
         last_grant <= grant[1];
      end
   end
`else
   // Fixed priority: requester 0 wins whenever it is asking, and nothing is
   // granted outside IDLE or while reset is held.
   always_comb begin
      grant = 2'b00;
      if (!rst && state == IDLE) begin
         if (req_valid[0]) begin
            grant = 2'b01;
         end else if (req_valid[1]) begin
            grant = 2'b10;
         end
      end
   end
`endif

   assign req_ready = grant;

   // Sequencer: capture the winner's request, register the ALU result one
   // cycle later, then hold the response until the consumer accepts it.
   // Reset throws away any operation in flight without producing a response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         id_q      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_zero  <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant != 2'b00) begin
                  op_q  <= grant[1] ? req_op1 : req_op0;
                  a_q   <= grant[1] ? req_a1  : req_a0;
                  b_q   <= grant[1] ? req_b1  : req_b0;
                  id_q  <= grant[1];
                  state <= EXEC;
               end
            end
            EXEC: begin
               rsp_data  <= alu_result;
               rsp_carry <= alu_carry;
               rsp_zero  <= (alu_result == '0);
               rsp_err   <= alu_err;
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. A transaction-level model predicts
// grants and pushes expected responses into a scoreboard queue; a separate
// monitor compares whatever the DUT presents against the queue head.
// Honours ALU_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_alu_arbiter;

   localparam int W = 20;
   localparam longint MOD = 64'd1 << W;

   typedef struct {
      int id;
      int data;
      int carry;
      int zero;
      int err;
   } exp_t;

   logic         clk;
   logic         rst;
   logic [1:0]   req_valid;
   logic [2:0]   req_op0;
   logic [2:0]   req_op1;
   logic [W-1:0] req_a0;
   logic [W-1:0] req_b0;
   logic [W-1:0] req_a1;
   logic [W-1:0] req_b1;
   logic [1:0]   req_ready;
   logic         rsp_valid;
   logic         rsp_ready;
   logic         rsp_id;
   logic [W-1:0] rsp_data;
   logic         rsp_carry;
   logic         rsp_zero;
   logic         rsp_err;

   exp_t sb_q[$];
   int   check_count = 0;
   int   err_count = 0;
   int   pend_valid[2];
   int   pend_op[2];
   int   pend_a[2];
   int   pend_b[2];
   int   m_phase;
   int   m_last;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_op0   (req_op0),
      .req_op1   (req_op1),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_carry (rsp_carry),
      .rsp_zero  (rsp_zero),
      .rsp_err   (rsp_err)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck design can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no end, want end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      check_count++;
      if (actual != expected) begin
         err_count++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference ALU from the opcode table, using ordinary integer arithmetic.
   function automatic exp_t refAlu(input int id, input int op, input int a, input int b);
      exp_t   r;
      longint la = longint'(a);
      longint lb = longint'(b);
      longint d = 0;
      r.id = id;
      r.carry = 0;
      r.err = 0;
      case (op)
         0: d = la & lb;
         1: d = la | lb;
         2: d = la ^ lb;
         3: begin
            d = (la + lb) % MOD;
            r.carry = ((la + lb) >= MOD) ? 1 : 0;
         end
         4: begin
            d = (la - lb + MOD) % MOD;
            r.carry = (la >= lb) ? 1 : 0;
         end
         5: d = (MOD - 1) - la;
         6: d = la;
         default: begin
            d = 0;
            r.err = 1;
         end
      endcase
      r.data = int'(d);
      r.zero = (d == 0) ? 1 : 0;
      return r;
   endfunction

   // Expected grant vector: nothing unless the unit is idle; a lone request
   // wins; a tie goes by policy.
   function automatic int modelGrant();
      if (m_phase != 0) return 0;
      if (pend_valid[0] != 0 && pend_valid[1] != 0) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
         return (m_last == 1) ? 1 : 2;
`else
         return 1;
`endif
      end
      if (pend_valid[0] != 0) return 1;
      if (pend_valid[1] != 0) return 2;
      return 0;
   endfunction

   task automatic applyStimulus(input int rdy);
      req_valid[0] = (pend_valid[0] != 0);
      req_valid[1] = (pend_valid[1] != 0);
      req_op0 = 3'(pend_op[0]);
      req_op1 = 3'(pend_op[1]);
      req_a0  = W'(pend_a[0]);
      req_b0  = W'(pend_b[0]);
      req_a1  = W'(pend_a[1]);
      req_b1  = W'(pend_b[1]);
      rsp_ready = (rdy != 0);
   endtask

   task automatic setRequest(input int id, input int op, input int a, input int b);
      pend_valid[id] = 1;
      pend_op[id] = op;
      pend_a[id] = a;
      pend_b[id] = b;
   endtask

   // One clock: drive, check grant and valid at the falling edge, then
   // advance the model at the rising edge and step just past it.
   task automatic stepCycle(input int rdy);
      int g;
      int w;
      applyStimulus(rdy);
      @(negedge clk);
      g = modelGrant();
      checkOutput("req_ready", int'(req_ready), g);
      checkOutput("rsp_valid", int'(rsp_valid), (m_phase == 2) ? 1 : 0);
      @(posedge clk);
      case (m_phase)
         0: begin
            if (g != 0) begin
               w = (g == 2) ? 1 : 0;
               sb_q.push_back(refAlu(w, pend_op[w], pend_a[w], pend_b[w]));
               m_last = w;
               pend_valid[w] = 0;
               m_phase = 1;
            end
         end
         1: m_phase = 2;
         default: if (rdy != 0) m_phase = 0;
      endcase
      #1;
   endtask

   // Run until every pending request is served and the unit is idle,
   // holding off the consumer for 'stall' cycles on the first response.
   task automatic runUntilIdle(input int stall);
      int left = stall;
      int rdy;
      for (int c = 0; c < 60; c++) begin
         if (pend_valid[0] == 0 && pend_valid[1] == 0 && m_phase == 0) return;
         rdy = 1;
         if (m_phase == 2 && left > 0) begin
            rdy = 0;
            left--;
         end
         stepCycle(rdy);
      end
      checkOutput("idle_timeout", 1, 0);
   endtask

   // Monitor: whenever a response is presented compare it with the head of
   // the scoreboard; retire it when the consumer accepts. While stalled the
   // same head is compared every cycle, which also checks the outputs hold.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && rsp_valid) begin
         if (sb_q.size() == 0) begin
            checkOutput("rsp_unexpected", 1, 0);
         end else begin
            e = sb_q[0];
            checkOutput("rsp_id", int'(rsp_id), e.id);
            checkOutput("rsp_data", int'(rsp_data), e.data);
            checkOutput("rsp_carry", int'(rsp_carry), e.carry);
            checkOutput("rsp_zero", int'(rsp_zero), e.zero);
            checkOutput("rsp_err", int'(rsp_err), e.err);
            if (rsp_ready) void'(sb_q.pop_front());
         end
      end
   end

   task automatic modelReset();
      m_phase = 0;
      m_last = 1;
      sb_q.delete();
      for (int i = 0; i < 2; i++) begin
         pend_valid[i] = 0;
         pend_op[i] = 0;
         pend_a[i] = 0;
         pend_b[i] = 0;
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req_ready"}, int'(req_ready), 0);
      checkOutput({tag, "_rsp_valid"}, int'(rsp_valid), 0);
      checkOutput({tag, "_rsp_id"}, int'(rsp_id), 0);
      checkOutput({tag, "_rsp_data"}, int'(rsp_data), 0);
      checkOutput({tag, "_rsp_carry"}, int'(rsp_carry), 0);
      checkOutput({tag, "_rsp_zero"}, int'(rsp_zero), 0);
      checkOutput({tag, "_rsp_err"}, int'(rsp_err), 0);
   endtask

   // Main sequence: reset, directed cases, reset during EXEC, random traffic.
   initial begin
      int mask;
      mask = int'(MOD - 1);
      modelReset();
      rst = 1'b1;
      setRequest(0, 0, 'hF0F0F, 'h0FFFF);
      applyStimulus(1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      $display("[TB] reset released, AND request from requester 0 pending");
      runUntilIdle(0);

      $display("[TB] tie traffic: ADD 1+1 on requester 0, SUB 5-5 on requester 1");
      for (int k = 0; k < 3; k++) begin
         setRequest(0, 3, 1, 1);
         setRequest(1, 4, 5, 5);
         runUntilIdle(0);
      end

      $display("[TB] ADD overflow to zero");
      setRequest(1, 3, 'hFFFFF, 'h00001);
      runUntilIdle(0);

      $display("[TB] consumer stall of 5 cycles with a second request waiting");
      setRequest(0, 2, 'h12345, 'h0F0F0);
      setRequest(1, 6, 'hABCDE, 0);
      runUntilIdle(5);

      $display("[TB] reserved opcode and NOT of zero");
      setRequest(0, 7, 'h11111, 'h22222);
      setRequest(1, 5, 0, 'h33333);
      runUntilIdle(0);

      $display("[TB] reset asserted during EXEC");
      setRequest(0, 3, 'h00010, 'h00020);
      stepCycle(1);
      checkOutput("mid_reset_phase_exec", m_phase, 1);
      pend_valid[1] = 1;
      applyStimulus(1);
      rst = 1'b1;
      #1;
      checkResetOutputs("async_reset");
      modelReset();
      applyStimulus(1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) stepCycle(1);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (pend_valid[i] == 0) begin
               if ($urandom_range(0, 1) == 1) begin
                  setRequest(i, int'($urandom_range(0, 7)),
                             ($urandom_range(0, 7) == 0) ? mask : int'($urandom) & mask,
                             ($urandom_range(0, 7) == 0) ? 0 : int'($urandom) & mask);
               end
            end else if ($urandom_range(0, 15) == 0) begin
               pend_valid[i] = 0;
            end
         end
         stepCycle(($urandom_range(0, 3) != 0) ? 1 : 0);
      end
      runUntilIdle(0);
      stepCycle(1);
      checkOutput("scoreboard_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, err_count);
      $finish;
   end

endmodule
